// File: rtl/table_dealer.sv
// Table-side command responder: deals cards from a 52-card deck using an LFSR search
// and keeps per-game pot and discard bookkeeping.
module table_dealer #(
   parameter logic [5:0] LFSR_SEED = 6'h01
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tbl_game_start,
   input  logic       tbl_game_over,
   input  logic       cr_cmdvld,
   input  logic [2:0] cr_cmd,
   input  logic [5:0] cr_wdata,
   output logic       cr_ack,
   output logic [7:0] cr_rdata,
   output logic       cr_rdatavld,
   output logic [5:0] cards_dealt,
   output logic [3:0] discard_count,
   output logic [7:0] pot,
   output logic       busy
);

   localparam logic [5:0] SEED = (LFSR_SEED == 6'd0) ? 6'h01 : LFSR_SEED;

   localparam logic [2:0] CMD_DEAL    = 3'b001;
   localparam logic [2:0] CMD_DISCARD = 3'b010;
   localparam logic [2:0] CMD_CHECK   = 3'b011;
   localparam logic [2:0] CMD_RAISE   = 3'b100;
   localparam logic [2:0] CMD_FOLD    = 3'b101;

   typedef enum logic [1:0] {IDLE, SEARCH, RESP, DROP} state_t;

   state_t      state, state_next;
   logic [51:0] used;
   logic [63:0] used_pad;
   logic [5:0]  lfsr;
   logic        game_active;
   logic [2:0]  cmd_q;
   logic [5:0]  wdata_q;
   logic        act_q;

   logic        ack_next, vld_next, accept;
   logic [7:0]  rdata_next;
   logic        hit_en, miss_en, disc_en, raise_en, fold_en;

   logic [5:0]  cand;
   logic        hit;
   logic [1:0]  cand_suit;
   logic [5:0]  cand_rank;
   logic [5:0]  disc_idx;
   logic        disc_ok;
   logic [8:0]  pot_sum;

   // Indices 52..63 read as used so that out-of-deck candidates count as misses
   assign used_pad = {12'hFFF, used};
   assign cand     = lfsr - 6'd1;
   assign hit      = ~used_pad[cand];
   assign disc_idx = ({4'd0, wdata_q[5:4]} * 6'd13) + {2'd0, wdata_q[3:0]} - 6'd1;
   assign disc_ok  = (wdata_q[3:0] >= 4'd1) && (wdata_q[3:0] <= 4'd13) && used_pad[disc_idx];
   assign pot_sum  = {1'b0, pot} + {3'd0, wdata_q};
   assign busy     = (state != IDLE);

   always_comb begin
      cand_suit = 2'd3;
      cand_rank = cand - 6'd38;
      if (cand < 6'd13) begin
         cand_suit = 2'd0;
         cand_rank = cand + 6'd1;
      end else if (cand < 6'd26) begin
         cand_suit = 2'd1;
         cand_rank = cand - 6'd12;
      end else if (cand < 6'd39) begin
         cand_suit = 2'd2;
         cand_rank = cand - 6'd25;
      end
   end

   always_comb begin
      state_next = state;
      ack_next   = 1'b0;
      vld_next   = 1'b0;
      rdata_next = cr_rdata;
      accept     = 1'b0;
      hit_en     = 1'b0;
      miss_en    = 1'b0;
      disc_en    = 1'b0;
      raise_en   = 1'b0;
      fold_en    = 1'b0;
      case (state)
         IDLE: begin
            if (cr_cmdvld && !tbl_game_start) begin
               accept   = 1'b1;
               ack_next = 1'b1;
               if (cr_cmd == CMD_DEAL && game_active && cards_dealt < 6'd52)
                  state_next = SEARCH;
               else
                  state_next = RESP;
            end
         end
         SEARCH: begin
            if (tbl_game_start) begin
               vld_next   = 1'b1;
               rdata_next = {2'b11, wdata_q};
               state_next = DROP;
            end else if (hit) begin
               hit_en     = 1'b1;
               vld_next   = 1'b1;
               rdata_next = {2'b00, cand_suit, cand_rank[3:0]};
               state_next = DROP;
            end else begin
               miss_en = 1'b1;
            end
         end
         RESP: begin
            vld_next   = 1'b1;
            state_next = DROP;
            if (tbl_game_start || !act_q) begin
               rdata_next = {2'b11, wdata_q};
            end else begin
               case (cmd_q)
                  CMD_DEAL: rdata_next = 8'h40;
                  CMD_DISCARD: begin
                     disc_en    = disc_ok;
                     rdata_next = {disc_ok ? 2'b00 : 2'b10, wdata_q};
                  end
                  CMD_CHECK: rdata_next = {2'b00, wdata_q};
                  CMD_RAISE: begin
                     raise_en   = 1'b1;
                     rdata_next = {2'b00, wdata_q};
                  end
                  CMD_FOLD: begin
                     fold_en    = 1'b1;
                     rdata_next = {2'b00, wdata_q};
                  end
                  default: rdata_next = {2'b10, wdata_q};
               endcase
            end
         end
         DROP: begin
            if (!cr_cmdvld) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Game start takes priority over every bookkeeping update, including game over
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         cr_ack        <= 1'b0;
         cr_rdatavld   <= 1'b0;
         cr_rdata      <= 8'd0;
         used          <= '0;
         lfsr          <= SEED;
         game_active   <= 1'b0;
         cards_dealt   <= 6'd0;
         discard_count <= 4'd0;
         pot           <= 8'd0;
         cmd_q         <= 3'd0;
         wdata_q       <= 6'd0;
         act_q         <= 1'b0;
      end else begin
         state       <= state_next;
         cr_ack      <= ack_next;
         cr_rdatavld <= vld_next;
         cr_rdata    <= rdata_next;
         if (accept) begin
            cmd_q   <= cr_cmd;
            wdata_q <= cr_wdata;
            act_q   <= game_active;
         end
         if (tbl_game_start) begin
            used          <= '0;
            lfsr          <= SEED;
            game_active   <= 1'b1;
            cards_dealt   <= 6'd0;
            discard_count <= 4'd0;
            pot           <= 8'd0;
         end else begin
            if (tbl_game_over || fold_en) game_active <= 1'b0;
            if (hit_en) begin
               used[cand]  <= 1'b1;
               cards_dealt <= cards_dealt + 6'd1;
            end
            if (miss_en) lfsr <= {lfsr[4:0], lfsr[5] ^ lfsr[4]};
            if (disc_en && discard_count != 4'd15) discard_count <= discard_count + 4'd1;
            if (raise_en) pot <= pot_sum[8] ? 8'hFF : pot_sum[7:0];
         end
      end
   end

endmodule

// File: tb/tb_table_dealer.sv
// Directed bench for table_dealer: a queue holds each command's expected response and
// a small deck/LFSR model supplies expected cards and search latencies.
module tb_table_dealer;

   localparam logic [2:0] CMD_DEAL    = 3'b001;
   localparam logic [2:0] CMD_DISCARD = 3'b010;
   localparam logic [2:0] CMD_CHECK   = 3'b011;
   localparam logic [2:0] CMD_RAISE   = 3'b100;
   localparam logic [2:0] CMD_FOLD    = 3'b101;

   logic       clk = 1'b0;
   logic       rst;
   logic       tbl_game_start, tbl_game_over;
   logic       cr_cmdvld;
   logic [2:0] cr_cmd;
   logic [5:0] cr_wdata;
   logic       cr_ack, cr_rdatavld, busy;
   logic [7:0] cr_rdata, pot;
   logic [5:0] cards_dealt;
   logic [3:0] discard_count;

   int         n_asserts = 0;
   int         n_fails   = 0;
   logic [7:0] sb_exp[$];
   logic [7:0] sb_mask[$];
   logic [7:0] last_rdata;

   logic [5:0] m_lfsr;
   logic       m_used[52];
   int         m_dealt;

   table_dealer #(.LFSR_SEED(6'h01)) dut (
      .clk(clk), .rst(rst),
      .tbl_game_start(tbl_game_start), .tbl_game_over(tbl_game_over),
      .cr_cmdvld(cr_cmdvld), .cr_cmd(cr_cmd), .cr_wdata(cr_wdata),
      .cr_ack(cr_ack), .cr_rdata(cr_rdata), .cr_rdatavld(cr_rdatavld),
      .cards_dealt(cards_dealt), .discard_count(discard_count),
      .pot(pot), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fails++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic checkResponse(input string tag);
      logic [7:0] e, m;
      if (sb_exp.size() == 0) begin
         checkOutput({tag, "_unexpected_resp"}, sb_exp.size(), 1);
      end else begin
         e = sb_exp.pop_front();
         m = sb_mask.pop_front();
         last_rdata = cr_rdata;
         checkOutput({tag, "_rdata"}, cr_rdata & m, e & m);
      end
   endtask

   function automatic void modelReset();
      m_lfsr  = 6'h01;
      m_dealt = 0;
      for (int i = 0; i < 52; i++) m_used[i] = 1'b0;
   endfunction

   function automatic void modelDeal(output logic [5:0] card, output int k);
      int cand, s, r;
      k = 0;
      cand = 0;
      for (int i = 0; i < 64; i++) begin
         cand = int'(m_lfsr) - 1;
         if (cand < 52 && !m_used[cand]) break;
         m_lfsr = {m_lfsr[4:0], m_lfsr[5] ^ m_lfsr[4]};
         k++;
      end
      m_used[cand] = 1'b1;
      m_dealt++;
      s = cand / 13;
      r = cand % 13 + 1;
      card = {s[1:0], r[3:0]};
   endfunction

   // One full handshake: drive, expect ack next edge, count acks/strobes until idle again
   task automatic applyStimulus(input string tag, input logic [2:0] cmd, input logic [5:0] wd,
                                input logic [7:0] exp, input logic [7:0] mask,
                                input int lat, input int hold);
      int cyc, ack_cnt, vld_cnt, vld_cyc, idle_cyc;
      sb_exp.push_back(exp);
      sb_mask.push_back(mask);
      @(negedge clk);
      cr_cmd    = cmd;
      cr_wdata  = wd;
      cr_cmdvld = 1'b1;
      @(posedge clk); #1;
      checkOutput({tag, "_ack"}, cr_ack, 1);
      ack_cnt  = int'(cr_ack);
      vld_cnt  = 0;
      vld_cyc  = -1;
      cyc      = 1;
      idle_cyc = 0;
      while (cyc < 100 && idle_cyc < 3) begin
         @(negedge clk);
         if (cyc > hold) cr_cmdvld = 1'b0;
         @(posedge clk); #1;
         cyc++;
         ack_cnt += int'(cr_ack);
         if (cr_rdatavld) begin
            vld_cnt++;
            vld_cyc = cyc;
            checkResponse(tag);
         end
         if (vld_cnt > 0 && !cr_cmdvld) idle_cyc++;
      end
      if (vld_cnt == 0 && sb_exp.size() > 0) begin
         void'(sb_exp.pop_front());
         void'(sb_mask.pop_front());
      end
      checkOutput({tag, "_ack_count"}, ack_cnt, 1);
      checkOutput({tag, "_vld_count"}, vld_cnt, 1);
      if (lat >= 0) checkOutput({tag, "_latency"}, vld_cyc, lat);
   endtask

   task automatic dealExpect(input string tag);
      logic [5:0] card;
      int k;
      if (m_dealt < 52) begin
         modelDeal(card, k);
         applyStimulus(tag, CMD_DEAL, 6'h00, {2'b00, card}, 8'hFF, 2 + k, 0);
      end else begin
         applyStimulus(tag, CMD_DEAL, 6'h00, 8'h40, 8'hFF, 2, 0);
      end
   endtask

   task automatic startGame();
      @(negedge clk);
      tbl_game_start = 1'b1;
      @(negedge clk);
      tbl_game_start = 1'b0;
      modelReset();
   endtask

   initial begin
      logic seen[64];
      int   dups;
      logic [7:0] exp_pot;

      rst = 1'b1;
      tbl_game_start = 1'b0;
      tbl_game_over  = 1'b0;
      cr_cmdvld = 1'b0;
      cr_cmd    = 3'd0;
      cr_wdata  = 6'd0;
      last_rdata = 8'd0;
      modelReset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      checkOutput("reset_ack", cr_ack, 0);
      checkOutput("reset_vld", cr_rdatavld, 0);
      checkOutput("reset_rdata", cr_rdata, 0);
      checkOutput("reset_dealt", cards_dealt, 0);
      checkOutput("reset_discard", discard_count, 0);
      checkOutput("reset_pot", pot, 0);
      checkOutput("reset_busy", busy, 0);

      $display("[TB] inactive deal before any game");
      applyStimulus("deal_inactive", CMD_DEAL, 6'h2A, 8'hEA, 8'hFF, 2, 0);

      $display("[TB] first two deals");
      startGame();
      dealExpect("deal1");
      checkOutput("deal1_card", last_rdata, 8'h01);
      dealExpect("deal2");
      checkOutput("deal2_card", last_rdata, 8'h02);
      checkOutput("dealt_two", cards_dealt, 2);

      $display("[TB] discards and illegal codes");
      applyStimulus("discard_ok", CMD_DISCARD, 6'h01, 8'h01, 8'hFF, 2, 0);
      checkOutput("discard_count1", discard_count, 1);
      applyStimulus("discard_rank14", CMD_DISCARD, 6'h0E, 8'h8E, 8'hFF, 2, 0);
      checkOutput("discard_count_still1", discard_count, 1);
      applyStimulus("illegal_111", 3'b111, 6'h05, 8'h85, 8'hFF, 2, 0);
      applyStimulus("illegal_000", 3'b000, 6'h3C, 8'hBC, 8'hFF, 2, 0);

      $display("[TB] held command valid");
      applyStimulus("check_hold", CMD_CHECK, 6'h11, 8'h00, 8'hC0, 2, 3);
      checkOutput("check_hold_dealt", cards_dealt, 2);

      $display("[TB] raise saturation");
      exp_pot = 8'd0;
      for (int i = 0; i < 5; i++) begin
         applyStimulus("raise", CMD_RAISE, 6'h3F, 8'h3F, 8'hFF, 2, 0);
         exp_pot = (i == 4) ? 8'd255 : exp_pot + 8'd63;
         checkOutput("raise_pot", pot, exp_pot);
      end

      $display("[TB] full deck");
      startGame();
      checkOutput("start_pot_clear", pot, 0);
      checkOutput("start_discard_clear", discard_count, 0);
      for (int i = 0; i < 64; i++) seen[i] = 1'b0;
      dups = 0;
      for (int i = 0; i < 52; i++) begin
         dealExpect("deck");
         if (seen[last_rdata[5:0]]) dups++;
         seen[last_rdata[5:0]] = 1'b1;
      end
      checkOutput("deck_distinct", dups, 0);
      dealExpect("deck_empty");
      checkOutput("deck_empty_card", last_rdata, 8'h40);
      checkOutput("deck_dealt52", cards_dealt, 52);

      $display("[TB] fold then deal");
      startGame();
      applyStimulus("fold", CMD_FOLD, 6'h00, 8'h00, 8'hC0, 2, 0);
      applyStimulus("deal_after_fold", CMD_DEAL, 6'h2A, 8'hEA, 8'hFF, 2, 0);

      $display("[TB] game over then check");
      startGame();
      @(negedge clk);
      tbl_game_over = 1'b1;
      @(negedge clk);
      tbl_game_over = 1'b0;
      applyStimulus("check_after_over", CMD_CHECK, 6'h11, 8'hD1, 8'hFF, 2, 0);

      $display("[TB] start aborts a search");
      startGame();
      dealExpect("pre_abort");
      sb_exp.push_back(8'hD5);
      sb_mask.push_back(8'hFF);
      @(negedge clk);
      cr_cmd    = CMD_DEAL;
      cr_wdata  = 6'h15;
      cr_cmdvld = 1'b1;
      @(posedge clk); #1;
      checkOutput("abort_ack", cr_ack, 1);
      checkOutput("abort_busy", busy, 1);
      @(negedge clk);
      tbl_game_start = 1'b1;
      cr_cmdvld      = 1'b0;
      @(posedge clk); #1;
      checkOutput("abort_vld", cr_rdatavld, 1);
      checkResponse("abort");
      checkOutput("abort_dealt", cards_dealt, 0);
      @(negedge clk);
      tbl_game_start = 1'b0;
      modelReset();
      repeat (3) @(posedge clk);
      dealExpect("deal_after_abort");
      checkOutput("deal_after_abort_card", last_rdata, 8'h01);
      checkOutput("deal_after_abort_dealt", cards_dealt, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
      $finish;
   end

endmodule
